// File: rtl/data_mem_responder.sv
// Wait-stated responder for the CPU data-memory port: latches one load/store request,
// holds it for WAIT_STATES cycles, then performs the access and pulses ready (and err on a fault).
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_read_en,
   input  logic        mem_write_en,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_STATES);
   localparam logic [33:0] SPAN_BYTES = 34'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state;
   state_t             stateNext;
   logic [3:0]         cnt;
   logic [3:0]         cntNext;
   logic               busyNext;
   logic               accept;
   logic               complete;

   logic [IDX_W-1:0]   idxQ;
   logic               faultQ;
   logic               opWriteQ;
   logic [31:0]        wdataQ;

   logic [31:0]        mem [DEPTH_WORDS];

   function automatic logic addrFault(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({2'b00, off} >= SPAN_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] wordIndex(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
         busy  <= 1'b0;
         ready <= 1'b0;
         err   <= 1'b0;
         rdata <= 32'h0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         busy  <= busyNext;
         ready <= complete;
         err   <= complete & faultQ;
         if (complete) begin
            if (faultQ)
               rdata <= 32'h0;
            else if (!opWriteQ)
               rdata <= mem[idxQ];
         end
      end
   end

   // Counter is loaded at accept and counts down to 1; the move to RESP happens on the edge
   // that would take it to 0, so ready lands WAIT_STATES+1 edges after acceptance.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      busyNext  = busy;
      accept    = 1'b0;
      complete  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_read_en || mem_write_en) begin
               accept    = 1'b1;
               busyNext  = 1'b1;
               cntNext   = WAIT_INIT;
               stateNext = (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt > 4'd1) begin
               cntNext = cnt - 4'd1;
            end else begin
               cntNext   = 4'd0;
               stateNext = ST_RESP;
            end
         end
         ST_RESP: begin
            complete  = 1'b1;
            busyNext  = 1'b0;
            stateNext = ST_IDLE;
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   // Request capture and storage; a store held in RESP while rst is low is discarded.
   always_ff @(posedge clk) begin
      if (accept) begin
         idxQ     <= wordIndex(addr);
         faultQ   <= addrFault(addr) | (mem_read_en & mem_write_en);
         opWriteQ <= mem_write_en;
         wdataQ   <= wdata;
      end
      if (complete && rst && !faultQ && opWriteQ)
         mem[idxQ] <= wdataQ;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: each request pushes its expected response,
// which is popped and compared when the ready pulse appears.
module tb_data_mem_responder;

   localparam int WS = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        mem_read_en = 1'b0;
   logic        mem_write_en = 1'b0;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
   logic        err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [256];
   logic [31:0] lastR = 32'h0;
   int          nChecks = 0;
   int          nFails = 0;

   data_mem_responder #(
      .DEPTH_WORDS(256),
      .WAIT_STATES(WS),
      .BASE_ADDR(32'h0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .addr(addr),
      .wdata(wdata),
      .mem_read_en(mem_read_en),
      .mem_write_en(mem_write_en),
      .rdata(rdata),
      .ready(ready),
      .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit scramble);
      exp_t e;
      logic bad;
      int   cycles;
      bit   got;
      bad = (rd & wr) || (a[1:0] != 2'b00) || (a >= 32'h400);
      e.err = bad;
      if (bad)
         e.rdata = 32'h0;
      else if (rd)
         e.rdata = model[a[9:2]];
      else
         e.rdata = lastR;
      if (!bad && wr)
         model[a[9:2]] = d;
      lastR = e.rdata;
      sb.push_back(e);

      addr = a; wdata = d; mem_read_en = rd; mem_write_en = wr;
      @(posedge clk); #1;
      nChecks++;
      if ({ready, err, busy} !== 3'b001) begin
         nFails++;
         $display("FAIL accept_state a=%h: ready/err/busy=%b required 001", a, {ready, err, busy});
      end
      if (scramble) begin
         addr = ~a ^ 32'h3; wdata = ~d;
      end else begin
         mem_read_en = 1'b0; mem_write_en = 1'b0;
      end
      cycles = 0; got = 0;
      while (!got && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
         if (ready === 1'b1) got = 1;
      end
      mem_read_en = 1'b0; mem_write_en = 1'b0;
      nChecks++;
      if (!got) begin
         nFails++;
         $display("FAIL ready_timeout a=%h: no ready within %0d cycles", a, cycles);
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      if (cycles !== WS + 1) begin
         nFails++;
         $display("FAIL latency a=%h: got %0d cycles required %0d", a, cycles, WS + 1);
      end
      nChecks++;
      if (err !== e.err) begin
         nFails++;
         $display("FAIL err a=%h: got %b required %b", a, err, e.err);
      end
      nChecks++;
      if (rdata !== e.rdata) begin
         nFails++;
         $display("FAIL rdata a=%h: got %h required %h", a, rdata, e.rdata);
      end
      nChecks++;
      if (busy !== 1'b0) begin
         nFails++;
         $display("FAIL busy_at_ready a=%h: got %b required 0", a, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         nChecks++;
         if ({ready, busy, err, rdata} !== 35'h0) begin
            nFails++;
            $display("FAIL reset_hold%0d: ready/busy/err/rdata=%b/%b/%b/%h required all 0",
                     i, ready, busy, err, rdata);
         end
      end
      rst = 1'b1;
      lastR = 32'h0;
      @(posedge clk); #1;
      nChecks++;
      if ({ready, busy, err, rdata} !== 35'h0) begin
         nFails++;
         $display("FAIL reset_release: ready/busy/err/rdata=%b/%b/%b/%h required all 0",
                  ready, busy, err, rdata);
      end
   endtask

   task automatic test_store_load();
      do_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      do_req(1'b0, 1'b1, 32'h3FC, 32'h0BAD_F00D, 1'b0);
      do_req(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
      do_req(1'b0, 1'b1, 32'h0, 32'h1111_2222, 1'b0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      do_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_errors();
      do_req(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
      do_req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
      do_req(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
      do_req(1'b0, 1'b1, 32'h12, 32'hBAD0_BAD0, 1'b0);
      do_req(1'b0, 1'b1, 32'h400, 32'hBAD1_BAD1, 1'b0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      do_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_illegal();
      do_req(1'b1, 1'b1, 32'h20, 32'h0000_0001, 1'b0);
      do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
   endtask

   task automatic test_latch();
      do_req(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b1);
      do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
   endtask

   task automatic test_reset_in_wait();
      bit sawReady;
      do_req(1'b0, 1'b1, 32'h30, 32'hA5A5_A5A5, 1'b0);
      addr = 32'h30; wdata = 32'h5A5A_5A5A; mem_write_en = 1'b1;
      @(posedge clk); #1;
      mem_write_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      nChecks++;
      if ({ready, busy, err} !== 3'b000) begin
         nFails++;
         $display("FAIL reset_in_wait: ready/busy/err=%b required 000", {ready, busy, err});
      end
      rst = 1'b1;
      lastR = 32'h0;
      sawReady = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (ready !== 1'b0) sawReady = 1;
      end
      nChecks++;
      if (sawReady) begin
         nFails++;
         $display("FAIL dropped_req_ready: got ready=1 required 0 after reset");
      end
      do_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         do_req(1'b1, 1'b0, 32'h40 + 32'(i % 2) * 32'h3BC, 32'h0, 1'b0);
      do_req(1'b0, 1'b1, 32'h80, 32'h7777_0001, 1'b0);
      do_req(1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_errors();
      test_illegal();
      test_latch();
      test_reset_in_wait();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
